// File: rtl/stream_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_demux: one-entry ready/valid demultiplexer routing words to one   |
// | of two outputs. Optional macro STREAM_DEMUX_COUNT_EN adds transfer counts.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stream_demux #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] in_data,
  input  logic         in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] out0_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [n-1:0] out1_data,
  output logic         out1_valid,
  input  logic         out1_ready
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [15:0]  out0_count,
  output logic [15:0]  out1_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL0 = 2'd1,
    FULL1 = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] data_q, data_d;
  logic         w_out0_fire, w_out1_fire, w_in_fire;

  always_comb begin
    w_out0_fire = (state_q == FULL0) && out0_ready;
    w_out1_fire = (state_q == FULL1) && out1_ready;
    // Refill in the same cycle the held word drains keeps full throughput.
    in_ready    = (state_q == EMPTY) || w_out0_fire || w_out1_fire;
    w_in_fire   = in_valid && in_ready;
    state_d     = state_q;
    data_d      = data_q;
    if (w_in_fire) begin
      data_d  = in_data;
      state_d = in_sel ? FULL1 : FULL0;
    end else if (w_out0_fire || w_out1_fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out0_valid = (state_q == FULL0);
  assign out1_valid = (state_q == FULL1);
  assign out0_data  = data_q;
  assign out1_data  = data_q;

`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0] out0_count_q, out0_count_d;
  logic [15:0] out1_count_q, out1_count_d;

  always_comb begin
    out0_count_d = out0_count_q + {15'd0, w_out0_fire};
    out1_count_d = out1_count_q + {15'd0, w_out1_fire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_count_q <= '0;
      out1_count_q <= '0;
    end else begin
      out0_count_q <= out0_count_d;
      out1_count_q <= out1_count_d;
    end
  end

  assign out0_count = out0_count_q;
  assign out1_count = out1_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// Randomized and directed checks of stream_demux against a one-entry
// routing buffer model held as a queue of accepted words.
module tb_stream_demux;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0] out0_count;
  logic [15:0] out1_count;
`endif

  stream_demux #(.n(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [7:0] data;
  } word_t;

  word_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cnt0 = 0;
  int    cnt1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance the model at posedge.
  task automatic cycle(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1);
    logic full, rdy, out_fire, in_fire;
    word_t w;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    full     = (q.size() != 0);
    rdy      = !full || (q[0].sel ? r1 : r0);
    out_fire = full && (q[0].sel ? r1 : r0);
    in_fire  = v && rdy;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    check("out0_valid", {31'd0, out0_valid}, {31'd0, full && !q[0].sel});
    check("out1_valid", {31'd0, out1_valid}, {31'd0, full && q[0].sel});
    if (full && !q[0].sel) check("out0_data", {24'd0, out0_data}, {24'd0, q[0].data});
    if (full && q[0].sel)  check("out1_data", {24'd0, out1_data}, {24'd0, q[0].data});
`ifdef STREAM_DEMUX_COUNT_EN
    check("out0_count", {16'd0, out0_count}, cnt0 & 32'hFFFF);
    check("out1_count", {16'd0, out1_count}, cnt1 & 32'hFFFF);
`endif
    @(posedge clk);
    if (out_fire) begin
      w = q.pop_front();
      if (w.sel) cnt1++; else cnt0++;
    end
    if (in_fire) begin
      w.sel = s; w.data = d;
      q.push_back(w);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'($urandom), 8'($urandom), 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("rst_data", {24'd0, out0_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single route to out1 right after reset.
    cycle(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
    idle(3);

    // Back-pressure on out0 while out1 is ready.
    cycle(1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    idle(2);

    // Full-throughput alternation.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'(i % 2 == 0), 8'(i), 1'b1, 1'b1);
    idle(2);

    // Asynchronous reset while holding 0x77 in FULL0.
    cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_data", {24'd0, out0_data}, 32'd0);
    q.delete();
    #1 rst = 1'b0;
    cycle(1'b1, 1'b1, 8'h42, 1'b1, 1'b1);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom), 1'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    idle(3);

`ifdef STREAM_DEMUX_COUNT_EN
    // Counter wrap: reset, then 65537 transfers to out0.
    @(negedge clk);
    rst = 1'b1; q.delete(); cnt0 = 0; cnt1 = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
    idle(2);
    check("wrap_out0_count", {16'd0, out0_count}, 32'd1);
    check("wrap_out1_count", {16'd0, out1_count}, 32'd0);
`endif

    check("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
